// File: rtl/iob_uart_rxfifo.sv
// UART RX drain buffer: fetches each byte from the core with a one-cycle read strobe.
// Bytes go into a first-word-fall-through FIFO; bytes arriving while it is full are counted as overruns.
module iob_uart_rxfifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int OVR_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    input  logic                  soft_rst_i,
    input  logic                  core_rx_ready_i,
    input  logic [7:0]            core_rx_data_i,
    output logic                  core_rx_ren_o,
    output logic                  m_valid_o,
    output logic [7:0]            m_data_o,
    input  logic                  m_ready_i,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  full_o,
    output logic                  overrun_o,
    output logic [OVR_W-1:0]      overrun_cnt_o,
    input  logic                  ovr_clr_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [OVR_W-1:0]      CNT_ONE    = OVR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [DEPTH_LOG2-1:0] wptr_reg, wptr_next;
    logic [DEPTH_LOG2-1:0] rptr_reg, rptr_next;
    logic [DEPTH_LOG2:0]   level_reg, level_next;
    logic                  overrun_reg, overrun_next;
    logic [OVR_W-1:0]      ovr_cnt_reg, ovr_cnt_next;
    logic [7:0]            mem [DEPTH];

    logic fetch, pop, push, drop;

    assign fetch = (state_reg == ST_FETCH);
    assign full_o = (level_reg == LEVEL_FULL);
    assign m_valid_o = (level_reg != '0);
    assign pop = m_valid_o & m_ready_i;
    // A full FIFO still accepts the byte when the head leaves in the same cycle.
    assign push = fetch & (~full_o | pop);
    assign drop = fetch & ~push;

    assign core_rx_ren_o = fetch;
    assign m_data_o      = m_valid_o ? mem[rptr_reg] : 8'h00;
    assign level_o       = level_reg;
    assign overrun_o     = overrun_reg;
    assign overrun_cnt_o = ovr_cnt_reg;

    always_comb begin
        state_next   = state_reg;
        wptr_next    = wptr_reg;
        rptr_next    = rptr_reg;
        level_next   = level_reg;
        overrun_next = overrun_reg;
        ovr_cnt_next = ovr_cnt_reg;

        case (state_reg)
            ST_IDLE:  if (core_rx_ready_i) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_WAIT;
            ST_WAIT:  if (!core_rx_ready_i) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        if (push) wptr_next = wptr_reg + PTR_ONE;
        if (pop)  rptr_next = rptr_reg + PTR_ONE;

        case ({push, pop})
            2'b10:   level_next = level_reg + LEVEL_ONE;
            2'b01:   level_next = level_reg - LEVEL_ONE;
            default: level_next = level_reg;
        endcase

        // A drop coinciding with a clear leaves exactly that one drop recorded.
        if (ovr_clr_i) begin
            overrun_next = drop;
            ovr_cnt_next = drop ? CNT_ONE : '0;
        end else if (drop) begin
            overrun_next = 1'b1;
            if (ovr_cnt_reg != '1) ovr_cnt_next = ovr_cnt_reg + CNT_ONE;
        end

        if (soft_rst_i) begin
            state_next   = ST_IDLE;
            wptr_next    = '0;
            rptr_next    = '0;
            level_next   = '0;
            overrun_next = 1'b0;
            ovr_cnt_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_reg   <= ST_IDLE;
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            level_reg   <= '0;
            overrun_reg <= 1'b0;
            ovr_cnt_reg <= '0;
        end else if (cke_i) begin
            state_reg   <= state_next;
            wptr_reg    <= wptr_next;
            rptr_reg    <= rptr_next;
            level_reg   <= level_next;
            overrun_reg <= overrun_next;
            ovr_cnt_reg <= ovr_cnt_next;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (cke_i && push && !soft_rst_i) mem[wptr_reg] <= core_rx_data_i;
    end

endmodule

// File: tb/tb_iob_uart_rxfifo.sv
// Bench for iob_uart_rxfifo: directed scenarios followed by random traffic, all
// compared against a queue-based model of the receive path; a second instance with a 2-bit drop counter shares the stimulus.
module tb_iob_uart_rxfifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       arst_n, cke, soft_rst, ready, m_ready, ovr_clr;
    logic [7:0] data;

    logic       ren, m_valid, full, ovr;
    logic [7:0] m_data, cnt;
    logic [4:0] level;
    logic       ren2, m_valid2, full2, ovr2;
    logic [7:0] m_data2;
    logic [4:0] level2;
    logic [1:0] cnt2;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] q[$];
    int         m_phase;   // 0 waiting for ready, 1 strobing, 2 waiting for ready to drop
    bit         m_ovr;
    int         m_cnt8, m_cnt2;

    always #5 clk = ~clk;

    iob_uart_rxfifo #(.DEPTH_LOG2(4), .OVR_W(8)) u_dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .soft_rst_i(soft_rst),
        .core_rx_ready_i(ready), .core_rx_data_i(data), .core_rx_ren_o(ren),
        .m_valid_o(m_valid), .m_data_o(m_data), .m_ready_i(m_ready),
        .level_o(level), .full_o(full), .overrun_o(ovr), .overrun_cnt_o(cnt),
        .ovr_clr_i(ovr_clr)
    );

    iob_uart_rxfifo #(.DEPTH_LOG2(4), .OVR_W(2)) u_dut2 (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .soft_rst_i(soft_rst),
        .core_rx_ready_i(ready), .core_rx_data_i(data), .core_rx_ren_o(ren2),
        .m_valid_o(m_valid2), .m_data_o(m_data2), .m_ready_i(m_ready),
        .level_o(level2), .full_o(full2), .overrun_o(ovr2), .overrun_cnt_o(cnt2),
        .ovr_clr_i(ovr_clr)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_phase = 0;
        m_ovr   = 1'b0;
        m_cnt8  = 0;
        m_cnt2  = 0;
    endtask

    // What one rising edge does, given the inputs currently applied.
    task automatic model_edge();
        bit dropped;
        if (!cke) return;
        if (soft_rst) begin
            model_reset();
            return;
        end
        dropped = 1'b0;
        if (m_ready && q.size() > 0) void'(q.pop_front());
        if (m_phase == 1) begin
            if (q.size() < DEPTH) q.push_back(data);
            else dropped = 1'b1;
        end
        if (ovr_clr) begin
            m_ovr  = dropped;
            m_cnt8 = dropped ? 1 : 0;
            m_cnt2 = dropped ? 1 : 0;
        end else if (dropped) begin
            m_ovr  = 1'b1;
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
        case (m_phase)
            0:       m_phase = ready ? 1 : 0;
            1:       m_phase = 2;
            default: m_phase = ready ? 2 : 0;
        endcase
    endtask

    task automatic check_all();
        chk("ren", ren, m_phase == 1);
        chk("valid", m_valid, q.size() != 0);
        if (q.size() != 0) chk("data", m_data, q[0]);
        chk("level", level, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("overrun", ovr, m_ovr);
        chk("ovr_cnt", cnt, m_cnt8);
        chk("ren2", ren2, m_phase == 1);
        chk("valid2", m_valid2, q.size() != 0);
        if (q.size() != 0) chk("data2", m_data2, q[0]);
        chk("level2", level2, q.size());
        chk("full2", full2, q.size() == DEPTH);
        chk("overrun2", ovr2, m_ovr);
        chk("ovr_cnt2", cnt2, m_cnt2);
    endtask

    task automatic cycle();
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Core-side handshake for one byte; optional pop/clear aligned with the fetch edge.
    task automatic send_byte(input logic [7:0] d, input bit pop_at_fetch, input bit clr_at_fetch,
                             input bit release_ready);
        int  pulses = 0;
        bit  done   = 1'b0;
        ready = 1'b1;
        data  = d;
        for (int k = 0; k < 8 && !done; k++) begin
            if (m_phase == 1) begin
                m_ready = pop_at_fetch;
                ovr_clr = clr_at_fetch;
                done    = 1'b1;
            end
            if (ren === 1'b1) pulses++;
            cycle();
            m_ready = 1'b0;
            ovr_clr = 1'b0;
        end
        if (release_ready) begin
            ready = 1'b0;
            data  = 8'($urandom);
            if (ren === 1'b1) pulses++;
            cycle();
            chk("ren_pulses", pulses, 1);
        end
    endtask

    task automatic drain_all();
        m_ready = 1'b1;
        while (q.size() > 0) cycle();
        m_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] last;
        arst_n = 1'b0; cke = 1'b1; soft_rst = 1'b0; ready = 1'b0;
        m_ready = 1'b0; ovr_clr = 1'b0; data = 8'h00;
        model_reset();

        // Reset state
        @(negedge clk);
        check_all();
        chk("reset_data", m_data, 8'h00);
        chk("reset_ren", ren, 1'b0);
        arst_n = 1'b1;

        // Single byte
        send_byte(8'hA5, 1'b0, 1'b0, 1'b1);
        chk("t1_valid", m_valid, 1'b1);
        chk("t1_data", m_data, 8'hA5);
        chk("t1_level", level, 5'd1);
        drain_all();

        // Fill to DEPTH and drain in order
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0, 1'b0, 1'b1);
        chk("t2_full", full, 1'b1);
        chk("t2_level", level, 5'd16);
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_order", m_data, 8'(i));
            cycle();
        end
        m_ready = 1'b0;
        chk("t2_empty", m_valid, 1'b0);

        // Drops while full
        for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'(8'hE0 + i), 1'b0, 1'b0, 1'b1);
        chk("t3_cnt", cnt, 8'd3);
        chk("t3_ovr", ovr, 1'b1);
        chk("t3_level", level, 5'd16);
        chk("t3_head", m_data, 8'h10);

        // Pop coinciding with the fetch of a full FIFO
        send_byte(8'h5A, 1'b1, 1'b0, 1'b1);
        chk("t4_level", level, 5'd16);
        chk("t4_cnt", cnt, 8'd3);
        m_ready = 1'b1;
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_order", m_data, (i < 15) ? 8'(8'h11 + i) : 8'h5A);
            last = m_data;
            cycle();
        end
        m_ready = 1'b0;
        chk("t4_last", last, 8'h5A);

        // Clear concurrent with a drop, then saturation of the narrow counter
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'b0, 1'b0, 1'b1);
        send_byte(8'h77, 1'b0, 1'b1, 1'b1);
        chk("t5_cnt_clr", cnt, 8'd1);
        chk("t5_cnt2_clr", cnt2, 2'd1);
        chk("t5_ovr_clr", ovr, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 1'b0, 1'b1);
        chk("t5_cnt2_sat", cnt2, 2'd3);
        chk("t5_cnt8", cnt, 8'd6);
        ovr_clr = 1'b1;
        cycle();
        ovr_clr = 1'b0;
        chk("t5_cleared", {ovr, cnt}, 9'd0);

        // Soft reset while waiting, then async reset during a fetch
        soft_rst = 1'b1;
        cycle();
        soft_rst = 1'b0;
        chk("t6_flush", level, 5'd0);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + i), 1'b0, 1'b0, 1'b1);
        send_byte(8'h34, 1'b0, 1'b0, 1'b0);
        chk("t6_level5", level, 5'd5);
        soft_rst = 1'b1;
        cycle();
        soft_rst = 1'b0;
        chk("t6_srst_level", level, 5'd0);
        chk("t6_srst_valid", m_valid, 1'b0);
        cycle();
        chk("t6_refetch_ren", ren, 1'b1);
        cycle();
        chk("t6_refetch_level", level, 5'd1);
        ready = 1'b0;
        cycle();
        ready = 1'b1;
        cycle();
        chk("t6_fetch_ren", ren, 1'b1);
        #2 arst_n = 1'b0;
        #1;
        chk("t6_arst_ren", ren, 1'b0);
        chk("t6_arst_level", level, 5'd0);
        chk("t6_arst_valid", m_valid, 1'b0);
        ready = 1'b0;
        #1 arst_n = 1'b1;
        model_reset();
        cycle();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            ready    = ($urandom_range(0, 3) != 0);
            data     = 8'($urandom);
            m_ready  = (i < 700) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cke      = ($urandom_range(0, 7) != 0);
            soft_rst = ($urandom_range(0, 99) == 0);
            ovr_clr  = ($urandom_range(0, 31) == 0);
            cycle();
        end
        cke = 1'b1; soft_rst = 1'b0; ovr_clr = 1'b0; ready = 1'b0; m_ready = 1'b0;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
